// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the 2x1 round-robin lane arbiter.
//   - arb_state_e : arbiter FSM state encoding (RESET, IDLE, ACTIVE, STALL)
//   - ARB_DATA_W  : default lane / FIFO data width
//   - ARB_CNT_W   : default width of the per-source word counters, which
//                   exist only when ARB_STATS_EN is defined
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int ARB_DATA_W = 8;
    localparam int ARB_CNT_W  = 16;

    typedef enum logic [1:0] {
        RESET  = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2,
        STALL  = 2'd3
    } arb_state_e;

endpackage : arb_pkg

// File: rtl/rr_grant_2.sv
// ---------------------------------------------------------------------------
// rr_grant_2
// Purely combinational two-way round-robin grant.
// Ports:
//   req[1:0]    in   request per source (bit i = source i non-empty)
//   last_grant  in   index of the most recently granted source
//   enable      in   0 forces the grant to zero
//   grant[1:0]  out  one-hot grant (or zero when nothing is granted)
// ---------------------------------------------------------------------------
module rr_grant_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            unique case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                // Contention: hand the lane to whoever did not get it last.
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule : rr_grant_2

// File: rtl/arbiter_2x1_8bits.sv
// ---------------------------------------------------------------------------
// arbiter_2x1_8bits
// Round-robin scheduler sharing one lane between two FWFT source FIFOs.
// The granted head word is popped combinationally and forwarded one cycle
// later on data_out with valid_out and its source tag on dest_out.
//
// Optional feature macro: ARB_STATS_EN -- adds per-source forwarded-word
// counters cnt0/cnt1 (CNT_W bits, wrapping). Without it those ports and the
// CNT_W parameter do not exist; all other behaviour is identical.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_L      in   asynchronous active-low reset
//   empty0/1     in   source FIFO empty flags
//   data_in0/1   in   FWFT head words (valid while matching empty is 0)
//   almost_full  in   downstream backpressure, blocks grants this cycle
//   pop0/1       out  combinational pop strobes (never both 1)
//   data_out     out  registered forwarded byte
//   valid_out    out  registered, 1 = data_out holds a new byte
//   dest_out     out  registered source index of data_out
//   cnt0/1       out  forwarded word counts (ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module arbiter_2x1_8bits
    import arb_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W
`ifdef ARB_STATS_EN
    ,
    parameter int CNT_W  = ARB_CNT_W
`endif
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              empty0,
    input  logic              empty1,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic              almost_full,
    output logic              pop0,
    output logic              pop1,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              dest_out
`ifdef ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
`endif
);

    arb_state_e        state_q, state_d;
    logic              last_grant_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              dest_q;

    logic              req;
    logic              enable;
    logic              go;
    logic [1:0]        grant;
    logic [DATA_W-1:0] grant_data;

    assign req    = !empty0 || !empty1;
    // Grants are blocked by state rather than by the clock, so an
    // asynchronous reset drops the pop strobes immediately.
    assign enable = (state_q != RESET) && !almost_full;
    assign go     = enable && req;

    rr_grant_2 u_rr_grant_2 (
        .req        ({!empty1, !empty0}),
        .last_grant (last_grant_q),
        .enable     (enable),
        .grant      (grant)
    );

    assign pop0       = grant[0];
    assign pop1       = grant[1];
    assign grant_data = grant[1] ? data_in1 : data_in0;

    always_comb begin
        state_d = IDLE;
        if (state_q == RESET) begin
            state_d = IDLE;
        end else if (req && almost_full) begin
            state_d = STALL;
        end else if (go) begin
            state_d = ACTIVE;
        end else begin
            state_d = IDLE;
        end
    end

    // FSM, round-robin pointer and output register share one process.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= RESET;
            last_grant_q <= 1'b1;   // makes source 0 the first winner
            data_q       <= '0;
            valid_q      <= 1'b0;
            dest_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (go) begin
                last_grant_q <= grant[1];
                data_q       <= grant_data;
                dest_q       <= grant[1];
                valid_q      <= 1'b1;
            end else begin
                valid_q      <= 1'b0;
            end
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign dest_out  = dest_q;

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (pop0) cnt0_q <= cnt0_q + CNT_W'(1);
            if (pop1) cnt1_q <= cnt1_q + CNT_W'(1);
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule : arbiter_2x1_8bits
